// File: rtl/counter_seq_if.sv
// Command-side handshake bundle for counter_seq: command offer/accept, abort,
// and completion status returned to the requester.
interface counter_seq_if #(
    parameter int unsigned STEP_W = 8
);
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [STEP_W-1:0] cmd_arg;
    logic              cmd_ready;
    logic              abort;
    logic              done;
    logic              sat_hit;
    logic [STEP_W-1:0] steps_done;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, abort,
        input  cmd_ready, done, sat_hit, steps_done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, abort,
        output cmd_ready, done, sat_hit, steps_done
    );
endinterface

// File: rtl/counter_seq.sv
// Command sequencer driving an external up/down counter (LOAD, UP, DOWN, RTZ).
// Define COUNTER_SEQ_SAT_EN to make UP/DOWN stop early at max_count/zero.
module counter_seq #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STEP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    counter_seq_if.slave     bus,
    output logic             load_n,
    output logic             ce,
    output logic             up_down,
    output logic [WIDTH-1:0] data_load,
    input  logic [WIDTH-1:0] count_out,
    input  logic             max_count,
    input  logic             zero
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_UP   = 2'd1;
    localparam logic [1:0] OP_DOWN = 2'd2;
    localparam logic [1:0] OP_RTZ  = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [1:0]        op_q, op_nxt;
    logic [STEP_W-1:0] rem_q, rem_nxt;
    logic [STEP_W-1:0] steps_q, steps_nxt;
    logic              ready;
    logic              accept;
    logic              sat_stop;
    logic              sat_set;

    assign ready          = (state == S_IDLE) && !bus.abort;
    assign accept         = bus.cmd_valid && ready;
    assign bus.cmd_ready  = ready;
    assign bus.done       = (state == S_DONE);
    assign bus.steps_done = steps_q;

`ifdef COUNTER_SEQ_SAT_EN
    logic sat_q;

    assign sat_stop = ((op_q == OP_UP) && max_count) || ((op_q == OP_DOWN) && zero);

    // Early-stop flag, reported alongside done and held until the next accept
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (accept) begin
            sat_q <= 1'b0;
        end else if (sat_set) begin
            sat_q <= 1'b1;
        end
    end

    assign bus.sat_hit = sat_q;
`else
    assign sat_stop    = 1'b0;
    assign bus.sat_hit = 1'b0;
`endif

    // count_out is observed only by the requester; it carries no control meaning here
    logic unused_inputs;
    assign unused_inputs = ^{count_out, max_count, sat_set};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= OP_LOAD;
            rem_q   <= '0;
            steps_q <= '0;
        end else begin
            state   <= state_nxt;
            op_q    <= op_nxt;
            rem_q   <= rem_nxt;
            steps_q <= steps_nxt;
        end
    end

    // Next state and counter-side strobes; abort gates strobes in the same cycle
    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        rem_nxt   = rem_q;
        steps_nxt = steps_q;
        sat_set   = 1'b0;
        load_n    = 1'b1;
        ce        = 1'b0;
        up_down   = 1'b1;
        data_load = '0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    op_nxt    = bus.cmd_op;
                    rem_nxt   = bus.cmd_arg;
                    steps_nxt = '0;
                    state_nxt = (bus.cmd_op == OP_LOAD) ? S_LOAD : S_COUNT;
                end
            end
            S_LOAD: begin
                data_load = rem_q[WIDTH-1:0];
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    load_n    = 1'b0;
                    state_nxt = S_DONE;
                end
            end
            S_COUNT: begin
                up_down = (op_q == OP_UP);
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else if (op_q == OP_RTZ) begin
                    if (zero) begin
                        state_nxt = S_DONE;
                    end else begin
                        ce        = 1'b1;
                        steps_nxt = (&steps_q) ? steps_q : steps_q + STEP_W'(1);
                    end
                end else if (rem_q == '0) begin
                    state_nxt = S_DONE;
                end else if (sat_stop) begin
                    sat_set   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    ce        = 1'b1;
                    rem_nxt   = rem_q - STEP_W'(1);
                    steps_nxt = steps_q + STEP_W'(1);
                    if (rem_q == STEP_W'(1)) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_counter_seq.sv
// Directed bench for counter_seq driving a behavioural 4-bit up/down counter.
module tb_counter_seq;
    localparam int unsigned WIDTH  = 4;
    localparam int unsigned STEP_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_n, ce, up_down;
    logic [WIDTH-1:0] data_load, count_out;
    logic             max_count, zero;
    logic [WIDTH-1:0] cnt_m;

    always #5 clk = ~clk;

    counter_seq_if #(.STEP_W(STEP_W)) bus ();

    counter_seq #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .load_n    (load_n),
        .ce        (ce),
        .up_down   (up_down),
        .data_load (data_load),
        .count_out (count_out),
        .max_count (max_count),
        .zero      (zero)
    );

    // Controlled counter
    always_ff @(posedge clk) begin
        if (rst)          cnt_m <= '0;
        else if (!load_n) cnt_m <= data_load;
        else if (ce)      cnt_m <= up_down ? cnt_m + 4'd1 : cnt_m - 4'd1;
    end
    assign count_out = cnt_m;
    assign max_count = (cnt_m == 4'hF);
    assign zero      = (cnt_m == 4'h0);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] arg;
        int         ce_n;
        int         cnt;
        int         steps;
        int         sat;
        int         lat;
        int         ld_n;
    } vec_t;

    vec_t vecs[11];

    // Issue one command and observe until done (bounded)
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg,
                           output int ce_n, output int ld_n, output int ld_val,
                           output int lat, output int ud_bad, output int both_bad,
                           output int sat, output int got_done, output int rdy_at_done,
                           output int cnt_at_done, output int steps_at_done);
        int guard;
        ce_n = 0; ld_n = 0; ld_val = -1; lat = -1; ud_bad = 0; both_bad = 0;
        sat = -1; got_done = 0; rdy_at_done = -1; cnt_at_done = -1; steps_at_done = -1;
        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (ce) begin
                ce_n++;
                if (up_down !== (op == 2'd1)) ud_bad++;
            end
            if (!load_n) begin
                ld_n++;
                ld_val = int'(data_load);
            end
            if (!load_n && ce) both_bad++;
            if (bus.done) begin
                got_done      = 1;
                lat           = i;
                sat           = int'(bus.sat_hit);
                rdy_at_done   = int'(bus.cmd_ready);
                cnt_at_done   = int'(count_out);
                steps_at_done = int'(bus.steps_done);
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ce_n, ld_n, ld_val, lat, ud_bad, both_bad, sat, got_done, rdy, cnt, steps;
        int n, seen;

        vecs[0]  = '{2'd0, 8'd9,  0, 9,  0, 0, 2, 1};
        vecs[1]  = '{2'd1, 8'd3,  3, 12, 3, 0, 4, 0};
        vecs[2]  = '{2'd0, 8'd14, 0, 14, 0, 0, 2, 1};
`ifdef COUNTER_SEQ_SAT_EN
        vecs[3]  = '{2'd1, 8'd5,  1, 15, 1, 1, 3, 0};
`else
        vecs[3]  = '{2'd1, 8'd5,  5, 3,  5, 0, 6, 0};
`endif
        vecs[4]  = '{2'd0, 8'd4,  0, 4,  0, 0, 2, 1};
        vecs[5]  = '{2'd3, 8'd77, 4, 0,  4, 0, 6, 0};
        vecs[6]  = '{2'd3, 8'd0,  0, 0,  0, 0, 2, 0};
`ifdef COUNTER_SEQ_SAT_EN
        vecs[7]  = '{2'd2, 8'd2,  0, 0,  0, 1, 2, 0};
`else
        vecs[7]  = '{2'd2, 8'd2,  2, 14, 2, 0, 3, 0};
`endif
        vecs[8]  = '{2'd0, 8'd5,  0, 5,  0, 0, 2, 1};
        vecs[9]  = '{2'd1, 8'd0,  0, 5,  0, 0, 2, 0};
        vecs[10] = '{2'd2, 8'd3,  3, 2,  3, 0, 4, 0};

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_arg   = 8'd0;
        bus.abort     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst cmd_ready",  bus.cmd_ready,  1);
        check("rst done",       bus.done,       0);
        check("rst sat_hit",    bus.sat_hit,    0);
        check("rst steps_done", bus.steps_done, 0);
        check("rst load_n",     load_n,         1);
        check("rst ce",         ce,             0);
        check("rst up_down",    up_down,        1);
        check("rst data_load",  data_load,      0);

        for (int v = 0; v < 11; v++) begin
            run_cmd(vecs[v].op, vecs[v].arg, ce_n, ld_n, ld_val, lat, ud_bad, both_bad,
                    sat, got_done, rdy, cnt, steps);
            check($sformatf("v%0d done seen", v),   got_done, 1);
            check($sformatf("v%0d latency", v),     lat,      vecs[v].lat);
            check($sformatf("v%0d ce cycles", v),   ce_n,     vecs[v].ce_n);
            check($sformatf("v%0d load cycles", v), ld_n,     vecs[v].ld_n);
            check($sformatf("v%0d count_out", v),   cnt,      vecs[v].cnt);
            check($sformatf("v%0d steps_done", v),  steps,    vecs[v].steps);
            check($sformatf("v%0d sat_hit", v),     sat,      vecs[v].sat);
            check($sformatf("v%0d up_down", v),     ud_bad,   0);
            check($sformatf("v%0d load+ce", v),     both_bad, 0);
            check($sformatf("v%0d ready in done", v), rdy,    0);
            if (vecs[v].op == 2'd0)
                check($sformatf("v%0d data_load", v), ld_val, int'(vecs[v].arg[3:0]));
            @(negedge clk);
            check($sformatf("v%0d done pulse", v),  bus.done,      0);
            check($sformatf("v%0d back idle", v),   bus.cmd_ready, 1);
        end

        // UP 10 from 2, aborted after two ce cycles
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        bus.cmd_arg   = 8'd10;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            @(negedge clk);
            if (ce) n++;
        end
        check("abort pre ce", n, 2);
        @(negedge clk);
        bus.abort = 1'b1;
        #1;
        check("abort ce",     ce,     0);
        check("abort load_n", load_n, 1);
        @(posedge clk);
        #1 bus.abort = 1'b0;
        @(negedge clk);
        check("abort idle",       bus.cmd_ready,  1);
        check("abort steps_done", bus.steps_done, 2);
        check("abort count_out",  count_out,      4);
        seen = int'(bus.done);
        repeat (2) begin
            @(negedge clk);
            seen += int'(bus.done);
        end
        check("abort no done", seen, 0);

        // abort held in IDLE blocks acceptance
        bus.abort     = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_arg   = 8'd11;
        #1;
        check("abort idle ready", bus.cmd_ready, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (!load_n || ce || bus.done) seen++;
        end
        check("abort idle no accept", seen, 0);
        bus.abort     = 1'b0;
        bus.cmd_valid = 1'b0;
        #1;
        check("abort idle ready back", bus.cmd_ready,  1);
        check("abort idle count",      count_out,      4);
        check("abort idle steps",      bus.steps_done, 2);

        // rst during COUNT overrides abort
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        bus.cmd_arg   = 8'd10;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            @(negedge clk);
            if (ce) n++;
        end
        check("rst mid pre ce", n, 3);
        rst       = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        check("rst mid cmd_ready",  bus.cmd_ready,  1);
        check("rst mid done",       bus.done,       0);
        check("rst mid sat_hit",    bus.sat_hit,    0);
        check("rst mid steps_done", bus.steps_done, 0);
        check("rst mid load_n",     load_n,         1);
        check("rst mid ce",         ce,             0);
        check("rst mid up_down",    up_down,        1);
        check("rst mid data_load",  data_load,      0);

        // Normal operation resumes after reset
        run_cmd(2'd0, 8'd6, ce_n, ld_n, ld_val, lat, ud_bad, both_bad, sat, got_done, rdy, cnt, steps);
        check("post rst done",  got_done, 1);
        check("post rst count", cnt,      6);
        check("post rst steps", steps,    0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
